// File: rtl/alp_qreg_slice_if.sv
// alp_qreg_slice_if: WBUS, shift-routing and step-counter signals of the ALP Q register slice.
interface alp_qreg_slice_if #(
    parameter int CNT_W = 6
);
    logic [1:0]       q_op_h;
    logic [1:0]       dsize_h;
    logic [31:0]      wbus_in_h;
    logic             q_rd_h;
    logic [31:0]      wbus_out_h;
    logic [31:0]      q_h;
    logic             q_si0_l;
    logic             q_si7_l;
    logic             q_si15_l;
    logic             q_si31_l;
    logic             q_so0_l;
    logic             q_so7_l;
    logic             q_so15_l;
    logic             q_so31_l;
    logic             step_ld_h;
    logic [CNT_W-1:0] step_in_h;
    logic             step_zero_h;
    modport slave (
        input  q_op_h, dsize_h, wbus_in_h, q_rd_h, q_si0_l, q_si7_l, q_si15_l, q_si31_l,
               step_ld_h, step_in_h,
        output wbus_out_h, q_h, q_so0_l, q_so7_l, q_so15_l, q_so31_l, step_zero_h
    );
    modport master (
        output q_op_h, dsize_h, wbus_in_h, q_rd_h, q_si0_l, q_si7_l, q_si15_l, q_si31_l,
               step_ld_h, step_in_h,
        input  wbus_out_h, q_h, q_so0_l, q_so7_l, q_so15_l, q_so31_l, step_zero_h
    );
endinterface

// File: rtl/alp_qreg_slice.sv
// alp_qreg_slice: 32-bit ALP Q register with size-aware shifting and a MUL/DIV step counter.
module alp_qreg_slice #(
    parameter int CNT_W = 6
) (
    input  logic            qdclk_l,
    input  logic            reset_l,
    alp_qreg_slice_if.slave bus
);
    logic [31:0]      r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ld, w_shl, w_shr, w_byte, w_word, w_long;
    logic [31:0]      w_q_shl, w_q_shr, w_q_nxt;

    assign w_ld   = bus.q_op_h == 2'b01;
    assign w_shl  = bus.q_op_h == 2'b10;
    assign w_shr  = bus.q_op_h == 2'b11;
    assign w_byte = bus.dsize_h == 2'b00;
    assign w_word = bus.dsize_h == 2'b01;
    assign w_long = bus.dsize_h[1];

    // Bits above the top bit of the current data size are held on both shift directions.
    assign w_q_shl = w_long ? {r_q[30:0], ~bus.q_si0_l} :
                     w_word ? {r_q[31:16], r_q[14:0], ~bus.q_si0_l} :
                              {r_q[31:8], r_q[6:0], ~bus.q_si0_l};
    assign w_q_shr = w_long ? {~bus.q_si31_l, r_q[31:1]} :
                     w_word ? {r_q[31:16], ~bus.q_si15_l, r_q[15:1]} :
                              {r_q[31:8], ~bus.q_si7_l, r_q[7:1]};
    assign w_q_nxt = w_ld ? bus.wbus_in_h : w_shl ? w_q_shl : w_shr ? w_q_shr : r_q;

    always_ff @(posedge qdclk_l or negedge reset_l) begin
        if (!reset_l) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q <= w_q_nxt;
            if (bus.step_ld_h)
                r_cnt <= bus.step_in_h;
            else if ((w_shl || w_shr) && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign bus.q_h         = r_q;
    assign bus.wbus_out_h  = bus.q_rd_h ? r_q : 32'h0;
    assign bus.step_zero_h = r_cnt == '0;
    assign bus.q_so0_l     = ~(w_shr & r_q[0]);
    assign bus.q_so7_l     = ~(w_shl & w_byte & r_q[7]);
    assign bus.q_so15_l    = ~(w_shl & w_word & r_q[15]);
    assign bus.q_so31_l    = ~(w_shl & w_long & r_q[31]);
endmodule

// File: doc/alp_qreg_slice.md
Name: alp_qreg_slice

Overview:
- 32-bit Q register of the ALP datapath, directly downstream of the ALK.
- Loads from WBUS, and shifts left or right once per cycle. Shift-in bits come from the ALK Q shift routing (q_si*_l); shift-out bits return to it (q_so*_l), honouring byte/word/long data size.
- A step counter counts MUL/DIV iterations and reports loop exhaustion back to the microsequencer.

Parameters:
- CNT_W, 6, width of the iteration step counter (max 63 steps)

Ports:
- qdclk_l  in  1  system clock; all state updates on rising edge
- reset_l  in  1  asynchronous active-low reset
- q_op_h  in  2  00 hold, 01 load from wbus_in_h, 10 shift left, 11 shift right
- dsize_h  in  2  00 byte, 01 word, 10 long, 11 long
- wbus_in_h  in  32  load data
- q_rd_h  in  1  drive Q onto wbus_out_h
- wbus_out_h  out  32  q when q_rd_h=1, else 0
- q_h  out  32  registered Q contents
- q_si0_l  in  1  shift-in for bit 0 on left shift (active low, from ALK)
- q_si7_l  in  1  shift-in for bit 7 on byte right shift
- q_si15_l  in  1  shift-in for bit 15 on word right shift
- q_si31_l  in  1  shift-in for bit 31 on long right shift
- q_so0_l  out  1  bit 0 shifted out on right shift (active low, to ALK)
- q_so7_l  out  1  bit 7 shifted out on byte left shift
- q_so15_l  out  1  bit 15 shifted out on word left shift
- q_so31_l  out  1  bit 31 shifted out on long left shift
- step_ld_h  in  1  load step counter
- step_in_h  in  CNT_W  step count load value
- step_zero_h  out  1  step counter equals 0

Behaviour:
- Reset: asynchronous on reset_l=0.
  - q=0 and counter=0, so step_zero_h=1 and wbus_out_h=0.
  - All q_so*_l outputs are 1 (released).
  - Reset mid-shift discards the operation immediately.
- Top bit T per dsize: byte T=7, word T=15, long T=31. Bits above T hold on any shift.
- Load (01): q <= wbus_in_h, full 32 bits, regardless of dsize. One-cycle latency to q_h.
- Shift left (10):
  - q[T:1] <= q[T-1:0]; q[0] <= ~q_si0_l.
  - q_so{T}_l = ~q[T] (combinational from current q). The other two left outputs stay 1.
- Shift right (11):
  - q[T-1:0] <= q[T:1]; q[T] <= ~q_si{T}_l.
  - q_so0_l = ~q[0].
  - Non-selected q_si inputs are ignored.
- q_so outputs are open-drain in the real part. They are modelled as active-low and held at 1 whenever the matching shift is not in progress: q_so0_l only on op 11, q_so7/15/31_l only on op 10 with the matching dsize.
- Step counter:
  - step_ld_h=1: counter <= step_in_h; no decrement that cycle, even if a shift occurs.
  - Otherwise, each shift cycle (op 10 or 11) with counter≠0 decrements by 1.
  - A shift with counter=0 leaves it at 0; no wrap.
  - Hold and load ops never change the counter.
- step_zero_h = (counter==0), registered-state derived. It asserts in the cycle after the final decrement.
- wbus_out_h is combinational from q and q_rd_h. A load and a read in the same cycle returns the old q.

Test Plan:
- Reset then release → q_h=0, step_zero_h=1, all q_so*_l=1, wbus_out_h=0. Then q_rd_h=1 → wbus_out_h=0.
- Load 0x8000_00F1, dsize=10, shift left, q_si0_l=0 → q_so31_l=0 during shift, q_h=0x0000_01E3; q_so7_l=q_so15_l=1.
- Load 0x1234_5681, dsize=00, shift right, q_si7_l=0 → q_so0_l=0 during shift, q_h=0x1234_56C0; upper 24 bits unchanged.
- Load 0xFFFF_8000, dsize=01, shift left, q_si0_l=1 → q_so15_l=0, q_h=0xFFFF_0000.
- step_ld_h with step_in_h=3, then 4 consecutive right shifts:
  - step_zero_h is 0 for cycles 1–3 and 1 after the third shift; it stays 1 after the fourth (no wrap).
  - step_ld_h coincident with a shift loads 3 with no decrement.
- Assert reset_l low mid-sequence (counter=2, q=0xA5A5_A5A5) → q_h=0 and step_zero_h=1 immediately, without waiting for a clock edge.
